wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/params_pkg.sv | 16 +
 rtl/wb_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared types and defaults for the instruction/data Wishbone arbiter.
package params_pkg;

    // Arbiter sequencing: wait for a request, run one bus cycle for the
    // granted side, then spend one cycle reporting completion.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    // Bus cycles allowed without ack/err before a transaction is aborted.
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single Wishbone B4 classic
// master. One transaction in flight at a time; all outputs are registered.
//
// Handshake: a side raises its req level with address/controls stable and
// holds it until its done pulse. done is a one-cycle pulse; err qualifies it
// and rdata is valid only in that cycle. A req still high in the cycle after
// done counts as a new request.
module wb_mem_arbiter
    import params_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_rdata_o,
    output logic        imem_done_o,
    output logic        imem_err_o,

    input  logic        dmem_req_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_sel_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_done_o,
    output logic        dmem_err_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,

    output logic        busy_o,
    output arb_state_t  state_o
);

    // Counter value seen in the last permitted GRANT cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        last_grant_d;  // 1: data side won the most recent grant
    logic [15:0] timeout_cnt;
    logic        pick_d;
    logic        pick_i;
    logic        bus_ok;
    logic        bus_end;

    // Data wins when it asks alone, or when both ask and fetch was served last.
    assign pick_d  = dmem_req_i && (!imem_req_i || !last_grant_d);
    assign pick_i  = imem_req_i && !pick_d;
    // An error, even alongside ack, turns the cycle into a failure.
    assign bus_ok  = wb_ack_i && !wb_err_i;
    assign bus_end = wb_ack_i || wb_err_i || (timeout_cnt == TIMEOUT_LAST);

    // Arbiter FSM with registered bus and completion outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_o      <= ARB_IDLE;
            last_grant_d <= 1'b0;
            timeout_cnt  <= '0;
            busy_o       <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            imem_rdata_o <= '0;
            imem_done_o  <= 1'b0;
            imem_err_o   <= 1'b0;
            dmem_rdata_o <= '0;
            dmem_done_o  <= 1'b0;
            dmem_err_o   <= 1'b0;
        end else begin
            // Completion outputs are single-cycle pulses.
            imem_done_o  <= 1'b0;
            imem_err_o   <= 1'b0;
            imem_rdata_o <= '0;
            dmem_done_o  <= 1'b0;
            dmem_err_o   <= 1'b0;
            dmem_rdata_o <= '0;

            case (state_o)
                ARB_IDLE: begin
                    if (pick_d) begin
                        state_o      <= ARB_GRANT_D;
                        last_grant_d <= 1'b1;
                        timeout_cnt  <= '0;
                        busy_o       <= 1'b1;
                        wb_cyc_o     <= 1'b1;
                        wb_stb_o     <= 1'b1;
                        wb_we_o      <= dmem_we_i;
                        wb_adr_o     <= dmem_addr_i;
                        wb_dat_o     <= dmem_wdata_i;
                        wb_sel_o     <= dmem_sel_i;
                    end else if (pick_i) begin
                        state_o      <= ARB_GRANT_I;
                        last_grant_d <= 1'b0;
                        timeout_cnt  <= '0;
                        busy_o       <= 1'b1;
                        wb_cyc_o     <= 1'b1;
                        wb_stb_o     <= 1'b1;
                        wb_we_o      <= 1'b0;
                        wb_adr_o     <= imem_addr_i;
                        wb_dat_o     <= '0;
                        wb_sel_o     <= 4'hF;
                    end
                end

                ARB_GRANT_I, ARB_GRANT_D: begin
                    if (bus_end) begin
                        state_o  <= ARB_RESP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (state_o == ARB_GRANT_D) begin
                            dmem_done_o  <= 1'b1;
                            dmem_err_o   <= !bus_ok;
                            dmem_rdata_o <= (bus_ok && !wb_we_o) ? wb_dat_i : '0;
                        end else begin
                            imem_done_o  <= 1'b1;
                            imem_err_o   <= !bus_ok;
                            imem_rdata_o <= bus_ok ? wb_dat_i : '0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                ARB_RESP: begin
                    state_o <= ARB_IDLE;
                    busy_o  <= 1'b0;
                end

                default: begin
                    state_o <= ARB_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: a transaction-level expectation queue
// plus a combined bus-slave/compare process checking every cycle.
module tb_wb_mem_arbiter;
    import params_pkg::*;

    localparam int TO     = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct {
        logic        side_d;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          kind;
        int          delay;
        logic [31:0] bus_dat;
    } txn_t;

    logic        clk;
    logic        rst_ni;
    logic        imem_req_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_rdata_o;
    logic        imem_done_o;
    logic        imem_err_o;
    logic        dmem_req_i;
    logic        dmem_we_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_sel_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_done_o;
    logic        dmem_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy_o;
    arb_state_t  state_o;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    bit   mon_en = 0;

    wb_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_rdata_o(imem_rdata_o), .imem_done_o(imem_done_o), .imem_err_o(imem_err_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_sel_i(dmem_sel_i),
        .dmem_rdata_o(dmem_rdata_o), .dmem_done_o(dmem_done_o), .dmem_err_o(dmem_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- scoreboard helper ----------------
    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus slave + per-cycle compare ----------------
    txn_t        cur;
    bit          prev_cyc    = 0;
    bit          bus_open    = 0;
    bit          expect_done = 0;
    int          bus_cycles  = 0;
    logic        exp_err;
    logic [31:0] exp_rd;

    // Outputs are sampled on the falling edge; slave responses are driven here too.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h5555_5555;
        if (!mon_en) begin
            prev_cyc    = 0;
            bus_open    = 0;
            expect_done = 0;
            bus_cycles  = 0;
        end else begin
            chk(!(imem_done_o && dmem_done_o), "both_done", {imem_done_o, dmem_done_o}, 0);
            chk(busy_o == (wb_cyc_o | imem_done_o | dmem_done_o), "busy",
                busy_o, wb_cyc_o | imem_done_o | dmem_done_o);

            if (expect_done) begin
                exp_err = (cur.kind != K_ACK);
                exp_rd  = (exp_err || cur.we) ? 32'h0 : cur.bus_dat;
                if (cur.side_d) begin
                    chk(dmem_done_o == 1'b1, "d_done", dmem_done_o, 1);
                    chk(dmem_err_o == exp_err, "d_err", dmem_err_o, exp_err);
                    chk(dmem_rdata_o == exp_rd, "d_rdata", dmem_rdata_o, exp_rd);
                    chk(!imem_done_o && !imem_err_o, "i_quiet", {imem_done_o, imem_err_o}, 0);
                end else begin
                    chk(imem_done_o == 1'b1, "i_done", imem_done_o, 1);
                    chk(imem_err_o == exp_err, "i_err", imem_err_o, exp_err);
                    chk(imem_rdata_o == exp_rd, "i_rdata", imem_rdata_o, exp_rd);
                    chk(!dmem_done_o && !dmem_err_o, "d_quiet", {dmem_done_o, dmem_err_o}, 0);
                end
                chk(wb_cyc_o == 1'b0, "cyc_drop", wb_cyc_o, 0);
                expect_done = 0;
            end else begin
                chk(!imem_done_o && !dmem_done_o && !imem_err_o && !dmem_err_o,
                    "spurious_done", {imem_done_o, imem_err_o, dmem_done_o, dmem_err_o}, 0);
            end

            if (!wb_cyc_o && bus_open) begin
                chk(0, "early_drop", bus_cycles, cur.delay);
                bus_open = 0;
            end

            if (wb_cyc_o && !prev_cyc) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_cycle", wb_adr_o, 0);
                end else begin
                    cur        = exp_q.pop_front();
                    bus_open   = 1;
                    bus_cycles = 0;
                end
            end

            if (wb_cyc_o && bus_open) begin
                bus_cycles++;
                chk(wb_stb_o == 1'b1, "wb_stb", wb_stb_o, 1);
                chk(wb_adr_o == cur.adr, "wb_adr", wb_adr_o, cur.adr);
                chk(wb_we_o == cur.we, "wb_we", wb_we_o, cur.we);
                chk(wb_sel_o == cur.sel, "wb_sel", wb_sel_o, cur.sel);
                if (cur.side_d) chk(wb_dat_o == cur.dat, "wb_dat", wb_dat_o, cur.dat);
                if (cur.kind == K_NONE) begin
                    if (bus_cycles == TO) begin
                        bus_open    = 0;
                        expect_done = 1;
                    end
                end else if (bus_cycles == cur.delay + 1) begin
                    wb_dat_i    = cur.bus_dat;
                    wb_ack_i    = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
                    wb_err_i    = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
                    bus_open    = 0;
                    expect_done = 1;
                end
            end
            prev_cyc = wb_cyc_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_txn(input logic side_d, input logic [31:0] adr, input logic we,
                          input logic [3:0] sel, input logic [31:0] dat, input int kind,
                          input int delay, input logic [31:0] bus_dat, input int drop_after,
                          output int n, output logic [31:0] rd, output logic er);
        txn_t t;
        t.side_d = side_d; t.adr = adr; t.we = we; t.sel = sel; t.dat = dat;
        t.kind = kind; t.delay = delay; t.bus_dat = bus_dat;
        exp_q.push_back(t);
        if (side_d) begin
            dmem_addr_i = adr; dmem_we_i = we; dmem_sel_i = sel; dmem_wdata_i = dat;
            dmem_req_i = 1'b1;
        end else begin
            imem_addr_i = adr;
            imem_req_i  = 1'b1;
        end
        n = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == drop_after) begin
                imem_req_i = 1'b0;
                dmem_req_i = 1'b0;
            end
            if (side_d ? dmem_done_o : imem_done_o) begin
                n  = i;
                rd = side_d ? dmem_rdata_o : imem_rdata_o;
                er = side_d ? dmem_err_o : imem_err_o;
                break;
            end
        end
        imem_req_i = 1'b0;
        dmem_req_i = 1'b0;
        if (n == 0) chk(0, "done_wait", 0, 1);
        @(negedge clk);
    endtask

    // Both sides request continuously; returns done sides in order (1 = data).
    task automatic run_contention(input int pairs, output logic [7:0] order);
        txn_t t;
        int nd = 0, ni = 0, total = 0;
        order = '0;
        for (int k = 0; k < pairs; k++) begin
            t.side_d = 1'b1; t.adr = 32'h1000 + 32'(k * 16); t.we = 1'b0; t.sel = 4'hF;
            t.dat = 32'hCAFE_0000; t.kind = K_ACK; t.delay = 0; t.bus_dat = 32'hD000_0000 + 32'(k);
            exp_q.push_back(t);
            t.side_d = 1'b0; t.adr = 32'h2000 + 32'(k * 16); t.we = 1'b0; t.sel = 4'hF;
            t.dat = 32'h0; t.kind = K_ACK; t.delay = 1; t.bus_dat = 32'h1000_0000 + 32'(k);
            exp_q.push_back(t);
        end
        dmem_we_i = 1'b0; dmem_sel_i = 4'hF; dmem_wdata_i = 32'hCAFE_0000;
        dmem_addr_i = 32'h1000; imem_addr_i = 32'h2000;
        dmem_req_i = 1'b1; imem_req_i = 1'b1;
        for (int i = 0; i < 200 && total < 2 * pairs; i++) begin
            @(negedge clk);
            if (dmem_done_o) begin
                order = {order[6:0], 1'b1}; nd++; total++;
                if (nd == pairs) dmem_req_i = 1'b0;
                else dmem_addr_i = 32'h1000 + 32'(nd * 16);
            end
            if (imem_done_o) begin
                order = {order[6:0], 1'b0}; ni++; total++;
                if (ni == pairs) imem_req_i = 1'b0;
                else imem_addr_i = 32'h2000 + 32'(ni * 16);
            end
        end
        if (total < 2 * pairs) chk(0, "contention_wait", total, 2 * pairs);
        dmem_req_i = 1'b0; imem_req_i = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    int          n;
    logic [31:0] rd;
    logic        er;
    logic [7:0]  order;

    initial begin
        rst_ni = 1'b0;
        imem_req_i = 1'b0; imem_addr_i = '0;
        dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0;
        dmem_wdata_i = '0; dmem_sel_i = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (3) @(negedge clk);

        chk(state_o == ARB_IDLE, "rst_state", state_o, ARB_IDLE);
        chk({wb_cyc_o, wb_stb_o, wb_we_o, busy_o} == 4'b0, "rst_ctrl",
            {wb_cyc_o, wb_stb_o, wb_we_o, busy_o}, 0);
        chk({imem_done_o, imem_err_o, dmem_done_o, dmem_err_o} == 4'b0, "rst_done",
            {imem_done_o, imem_err_o, dmem_done_o, dmem_err_o}, 0);
        chk(wb_adr_o == 32'h0 && wb_sel_o == 4'h0, "rst_adr", wb_adr_o, 0);

        rst_ni = 1'b1;
        mon_en = 1;
        @(negedge clk);

        // Contention straight after reset: data first, then alternating.
        run_contention(2, order);
        chk(order[3:0] == 4'b1010, "contention_order", order[3:0], 4'b1010);

        // Single-cycle load.
        do_txn(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, K_ACK, 0, 32'hDEAD_BEEF, 0, n, rd, er);
        chk(n == 2, "load_latency", n, 2);
        chk(rd == 32'hDEAD_BEEF, "load_rdata", rd, 32'hDEAD_BEEF);
        chk(er == 1'b0, "load_err", er, 0);

        // Fetch with two wait states.
        do_txn(1'b0, 32'h40, 1'b0, 4'hF, 32'h0, K_ACK, 2, 32'h1234_5678, 0, n, rd, er);
        chk(n == 4, "fetch_latency", n, 4);
        chk(rd == 32'h1234_5678, "fetch_rdata", rd, 32'h1234_5678);

        // Store, partial lanes, three wait states.
        do_txn(1'b1, 32'h200, 1'b1, 4'b0011, 32'hA5A5_A5A5, K_ACK, 3, 32'h7777_7777, 0, n, rd, er);
        chk(rd == 32'h0, "store_rdata", rd, 0);
        chk(er == 1'b0, "store_err", er, 0);

        // Fetch that never gets a response.
        do_txn(1'b0, 32'h80, 1'b0, 4'hF, 32'h0, K_NONE, 0, 32'h0, 0, n, rd, er);
        chk(n == 5, "timeout_latency", n, 5);
        chk(er == 1'b1, "timeout_err", er, 1);
        chk(rd == 32'h0, "timeout_rdata", rd, 0);

        // Error response on a load.
        do_txn(1'b1, 32'h140, 1'b0, 4'hF, 32'h0, K_ERR, 1, 32'hFFFF_0000, 0, n, rd, er);
        chk(er == 1'b1 && rd == 32'h0, "err_load", {er, rd[30:0]}, 32'h8000_0000);

        // Ack and error together: error wins.
        do_txn(1'b1, 32'h180, 1'b0, 4'b1100, 32'h0, K_BOTH, 0, 32'h1357_2468, 0, n, rd, er);
        chk(er == 1'b1, "ackerr_err", er, 1);
        chk(rd == 32'h0, "ackerr_rdata", rd, 0);

        // Request withdrawn while the bus cycle is running.
        do_txn(1'b0, 32'h60, 1'b0, 4'hF, 32'h0, K_ACK, 3, 32'h0F0F_0F0F, 1, n, rd, er);
        chk(n == 5, "drop_latency", n, 5);
        chk(rd == 32'h0F0F_0F0F, "drop_rdata", rd, 32'h0F0F_0F0F);

        // Reset in the middle of a data bus cycle.
        mon_en = 0;
        dmem_addr_i = 32'h300; dmem_we_i = 1'b0; dmem_sel_i = 4'hF;
        dmem_req_i = 1'b1;
        repeat (2) @(negedge clk);
        chk(wb_cyc_o == 1'b1 && state_o == ARB_GRANT_D, "abort_granted", {wb_cyc_o, state_o}, 32'h6);
        rst_ni = 1'b0;
        dmem_req_i = 1'b0;
        @(negedge clk);
        chk(wb_cyc_o == 1'b0, "abort_cyc", wb_cyc_o, 0);
        chk(busy_o == 1'b0, "abort_busy", busy_o, 0);
        chk(dmem_done_o == 1'b0, "abort_done", dmem_done_o, 0);
        chk(state_o == ARB_IDLE, "abort_state", state_o, ARB_IDLE);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(!dmem_done_o && !wb_cyc_o, "abort_quiet", {dmem_done_o, wb_cyc_o}, 0);
        end
        mon_en = 1;
        @(negedge clk);

        // Reset restores the grant history: data wins again.
        run_contention(1, order);
        chk(order[1:0] == 2'b10, "post_reset_order", order[1:0], 2'b10);

        repeat (2) @(negedge clk);
        chk(exp_q.size() == 0, "exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
